alu_uart_interface: RTL
=======================

// Module: alu_uart_interface
// PURPOSE
//  Serial-side counterpart of the switch/button ALU front end. Collects operand A, operand B
//  and opcode as a byte stream from the UART receiver, presents them to the ALU, captures the
//  combinational result and hands it to the UART transmitter. Sits between uart_rx/uart_tx
//  and the ALU, replacing manual button loading with a host-driven request/response.
// PARAMETERS
//  N_BITS          8        width of A, B, opcode, result and each rx/tx byte
//  TIMEOUT_CYCLES  1000000  max idle cycles between bytes of one request; 0 disables timeout
// PORTS
//  clock          in   1       system clock, all state on rising edge
//  reset          in   1       asynchronous, active-low reset
//  i_rx_data      in   N_BITS  byte from uart_rx, valid only while i_rx_done=1
//  i_rx_done      in   1       1-cycle strobe: new rx byte
//  i_alu_result   in   N_BITS  combinational ALU result for current o_A/o_B/o_Op
//  i_tx_done      in   1       1-cycle strobe from uart_tx: previous byte fully sent
//  o_A            out  N_BITS  operand A to ALU (registered)
//  o_B            out  N_BITS  operand B to ALU (registered)
//  o_Op           out  N_BITS  opcode to ALU (registered)
//  o_tx_data      out  N_BITS  result byte to uart_tx, held stable from o_tx_start until i_tx_done
//  o_tx_start     out  1       1-cycle strobe: start transmitting o_tx_data
//  o_rx_drop      out  1       1-cycle strobe: rx byte arrived while busy and was discarded
//  o_timeout      out  1       1-cycle strobe: partial request abandoned
// BEHAVIOUR
//  - Reset (reset=0, async): state=WAIT_A; o_A,o_B,o_Op,o_tx_data=0; all strobes=0; timer=0.
//  - FSM: WAIT_A -> WAIT_B -> WAIT_OP -> LATCH -> SEND -> WAIT_TX -> WAIT_A.
//    WAIT_A/B/OP: on i_rx_done load byte into o_A/o_B/o_Op resp., advance; timer cleared.
//    LATCH: one cycle; ALU settles on new o_Op; o_tx_data <= i_alu_result at end of cycle.
//    SEND: o_tx_start=1 for exactly this cycle; next WAIT_TX.
//    WAIT_TX: wait for i_tx_done; then WAIT_A. i_tx_done in any other state is ignored.
//  - Latency: opcode strobe at edge k -> LATCH cycle k+1 -> o_tx_start high in cycle k+2.
//  - i_rx_done in LATCH/SEND/WAIT_TX: byte discarded, o_rx_drop=1 next cycle, no state change.
//  - Timeout: in WAIT_B/WAIT_OP timer counts cycles without i_rx_done; on reaching
//    TIMEOUT_CYCLES-1 -> WAIT_A, o_timeout=1 one cycle; o_A/o_B/o_Op keep last values.
//    i_rx_done in the same cycle as expiry wins: byte accepted, no timeout. Timer held at 0
//    in WAIT_A and non-rx states. TIMEOUT_CYCLES=0: timer never expires.
//  - o_A/o_B/o_Op change only on accepted bytes; ALU output stays valid between requests.
//  - o_tx_data only written in LATCH; stable through WAIT_TX.
//  - Reset mid-request or mid-transmit: immediate return to reset values; no tx strobe issued.
//  - Timer width = $clog2(TIMEOUT_CYCLES+1), min 1; no wrap (saturating compare).
// STRUCTURE
//  - Shared package alu_if_pkg: state encoding localparams (WAIT_A, WAIT_B, WAIT_OP, LATCH,
//    SEND, WAIT_TX; 3 bits), default N_BITS, default TIMEOUT_CYCLES.
//  - Sub-module rx_timeout_counter (params TIMEOUT_CYCLES; in clear, enable; out expired).
//  - Top-level integration: uart_rx -> alu_uart_interface -> ALU; interface -> uart_tx.
// TESTING
//  1 Basic: rx 0x05,0x03,0x20(ADD) -> o_A=05,o_B=03,o_Op=20; o_tx_start 2 cycles after
//    opcode strobe with o_tx_data=0x08; i_tx_done -> back to WAIT_A.
//  2 Back-to-back: two requests (0x0F,0x01,SUB=0x22 -> 0x0E; 0xF0,0x0F,OR=0x25 -> 0xFF),
//    second A byte sent one cycle after i_tx_done -> both results correct, no drops.
//  3 Busy drop: rx strobe during WAIT_TX -> o_rx_drop pulse, o_A unchanged, next request OK.
//  4 Timeout (TIMEOUT_CYCLES=16): rx A, then silence -> o_timeout at cycle 16, state WAIT_A;
//    rx byte on expiry cycle instead -> accepted into o_B, no o_timeout.
//  5 Reset mid-op: assert reset in WAIT_OP and in WAIT_TX, asynchronously between edges ->
//    all outputs 0 immediately, no o_tx_start after release; fresh request works.
//  6 Ignored strobe: i_tx_done pulsed in WAIT_A/WAIT_B -> no state change, no output change.

Source files
------------

// File: rtl/alu_if_pkg.sv
// Shared definitions for the serial ALU front end: FSM states, default
// parameter values and the timeout counter width helper.
package alu_if_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    LATCH   = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam int unsigned DEFAULT_N_BITS         = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;

  function automatic int unsigned timer_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags
// expiry on the cycle the count sits at TIMEOUT_CYCLES-1 (never when 0).
module rx_timeout_counter
  import alu_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;
  logic         w_at_limit;

  // Saturating compare keeps the count from ever wrapping past the limit.
  assign w_at_limit = (TIMEOUT_CYCLES != 0) && (r_count >= LIMIT);
  assign o_expired  = i_enable && w_at_limit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear || !i_enable) begin
      r_count <= '0;
    end else if (!w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Host-driven ALU front end: gathers A, B and opcode bytes from the UART
// receiver, latches the ALU result and hands it to the UART transmitter.
module alu_uart_interface
  import alu_if_pkg::*;
#(
  parameter int unsigned N_BITS         = DEFAULT_N_BITS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic [N_BITS-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_BITS-1:0] o_Op,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_rx_drop,
  output logic              o_timeout
);

  state_t            r_state, w_next_state;
  logic [N_BITS-1:0] r_A, r_B, r_Op, r_tx_data;
  logic              r_rx_drop, r_timeout;
  logic              w_rx_state, w_expired;
  logic              w_load_a, w_load_b, w_load_op, w_load_tx, w_drop, w_timeout;

  assign w_rx_state = (r_state == WAIT_B) || (r_state == WAIT_OP);

  rx_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx_timeout_counter (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (i_rx_done),
    .i_enable  (w_rx_state),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_load_tx    = 1'b0;
    w_drop       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (i_rx_done) begin
          w_load_a     = 1'b1;
          w_next_state = WAIT_B;
        end
      end
      // A byte arriving on the expiry cycle takes priority over the timeout.
      WAIT_B: begin
        if (i_rx_done) begin
          w_load_b     = 1'b1;
          w_next_state = WAIT_OP;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          w_load_op    = 1'b1;
          w_next_state = LATCH;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = WAIT_A;
        end
      end
      LATCH: begin
        w_load_tx    = 1'b1;
        w_drop       = i_rx_done;
        w_next_state = SEND;
      end
      SEND: begin
        w_drop       = i_rx_done;
        w_next_state = WAIT_TX;
      end
      WAIT_TX: begin
        w_drop = i_rx_done;
        if (i_tx_done) w_next_state = WAIT_A;
      end
      default: w_next_state = WAIT_A;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= WAIT_A;
      r_A       <= '0;
      r_B       <= '0;
      r_Op      <= '0;
      r_tx_data <= '0;
      r_rx_drop <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rx_drop <= w_drop;
      r_timeout <= w_timeout;
      if (w_load_a)  r_A       <= i_rx_data;
      if (w_load_b)  r_B       <= i_rx_data;
      if (w_load_op) r_Op      <= i_rx_data;
      if (w_load_tx) r_tx_data <= i_alu_result;
    end
  end

  assign o_A        = r_A;
  assign o_B        = r_B;
  assign o_Op       = r_Op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = (r_state == SEND);
  assign o_rx_drop  = r_rx_drop;
  assign o_timeout  = r_timeout;

endmodule
